// File: rtl/videocard_pkg.sv
// Shared definitions for the videocard dispatch block: the control register
// map, the per-core state encoding and a counter-width helper.
package videocard_pkg;

    localparam logic [1:0] ADDR_START    = 2'd0;
    localparam logic [1:0] ADDR_DONE     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_ERROR    = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } core_state_t;

    // A disabled timeout still needs a legal one-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/videocard_core_ctl.sv
// Per-core IDLE/RUN controller with run-cycle timeout counter.
//   state   | meaning
//   ST_IDLE | core not running; accepts a start request
//   ST_RUN  | core running; waits for finish or timeout
module videocard_core_ctl
    import videocard_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_finish,
    output logic o_run,
    output logic o_go,
    output logic o_start_pulse,
    output logic o_done_set,
    output logic o_err_set
);

    localparam int              CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT);

    core_state_t      r_state;
    core_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_pulse;
    logic             w_tc;
    logic             w_go;
    logic             w_done_set;
    logic             w_err_set;

    // Timeout fires on the edge that completes TIMEOUT cycles spent in RUN.
    assign w_tc = (TIMEOUT > 0) && (r_state == ST_RUN) && (r_cnt == CNT_TC);

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_go        = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_finish) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tc) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_start_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_pulse <= w_go;
            if ((TIMEOUT > 0) && (r_state == ST_RUN)) begin
                if (r_cnt != CNT_SAT) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_run         = (r_state == ST_RUN);
    assign o_go          = w_go;
    assign o_start_pulse = r_start_pulse;
    assign o_done_set    = w_done_set;
    assign o_err_set     = w_err_set;

endmodule

// File: rtl/videocard_dispatch.sv
// Host-facing dispatcher: START/DONE/IRQ_MASK/ERROR register file, per-core
// start/finish handshakes and a masked, registered host interrupt.
module videocard_dispatch
    import videocard_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int WIDTH_CTRL = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset_n,
    input  logic [1:0]            address_control,
    input  logic                  read_control,
    input  logic                  write_control,
    input  logic [WIDTH_CTRL-1:0] data_in_control,
    output logic [WIDTH_CTRL-1:0] data_out_control,
    output logic [CORES-1:0]      interrupt_start,
    input  logic [CORES-1:0]      interrupt_finish,
    output logic                  irq
);

    logic [CORES-1:0]      w_run;
    logic [CORES-1:0]      w_go;
    logic [CORES-1:0]      w_start_pulse;
    logic [CORES-1:0]      w_done_set;
    logic [CORES-1:0]      w_err_set;
    logic [CORES-1:0]      w_start_req;
    logic [CORES-1:0]      w_done_clr;
    logic [CORES-1:0]      w_err_clr;
    logic [CORES-1:0]      w_wdata;
    logic [CORES-1:0]      r_done;
    logic [CORES-1:0]      r_err;
    logic [CORES-1:0]      r_mask;
    logic [WIDTH_CTRL-1:0] r_dout;
    logic [WIDTH_CTRL-1:0] w_rd_data;
    logic                  r_active;
    logic                  r_irq;
    logic                  w_wr_ok;
    logic                  w_unused;

    assign w_unused = &{1'b0, data_in_control};
    assign w_wdata  = data_in_control[CORES-1:0];

    // Writes are dropped in the first cycle after reset release.
    assign w_wr_ok     = write_control && r_active;
    assign w_start_req = (w_wr_ok && address_control == ADDR_START) ? w_wdata : '0;
    assign w_done_clr  = (w_wr_ok && address_control == ADDR_DONE)  ? w_wdata : '0;
    assign w_err_clr   = (w_wr_ok && address_control == ADDR_ERROR) ? w_wdata : '0;

    for (genvar g = 0; g < CORES; g++) begin : g_core
        videocard_core_ctl #(
            .TIMEOUT(TIMEOUT)
        ) u_core (
            .clk          (clk),
            .rst_n        (reset_sink_reset_n),
            .i_start      (w_start_req[g]),
            .i_finish     (interrupt_finish[g]),
            .o_run        (w_run[g]),
            .o_go         (w_go[g]),
            .o_start_pulse(w_start_pulse[g]),
            .o_done_set   (w_done_set[g]),
            .o_err_set    (w_err_set[g])
        );
    end

    always_comb begin
        w_rd_data = '0;
        case (address_control)
            ADDR_START:    w_rd_data = WIDTH_CTRL'(w_run);
            ADDR_DONE:     w_rd_data = WIDTH_CTRL'(r_done);
            ADDR_IRQ_MASK: w_rd_data = WIDTH_CTRL'(r_mask);
            ADDR_ERROR:    w_rd_data = WIDTH_CTRL'(r_err);
            default:       w_rd_data = '0;
        endcase
    end

    // Status sets from the cores take priority over host write-1-to-clear.
    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_active <= 1'b0;
            r_done   <= '0;
            r_err    <= '0;
            r_mask   <= '0;
            r_dout   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_done   <= (r_done & ~w_done_clr & ~w_go) | w_done_set;
            r_err    <= (r_err & ~w_err_clr & ~w_go) | w_err_set;
            if (w_wr_ok && address_control == ADDR_IRQ_MASK) begin
                r_mask <= w_wdata;
            end
            if (read_control) begin
                r_dout <= w_rd_data;
            end
            r_irq <= |((r_done | r_err) & r_mask);
        end
    end

    assign data_out_control = r_dout;
    assign interrupt_start  = w_start_pulse;
    assign irq              = r_irq;

endmodule

// File: tb/tb_videocard_dispatch.sv
// Randomized and directed bench for videocard_dispatch against a cycle-level
// behavioural model of the register map and per-core run rules.
module tb_videocard_dispatch;

    localparam int CORES = 4;
    localparam int WCTRL = 8;
    localparam int TMO   = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       address_control = '0;
    logic             read_control = 1'b0;
    logic             write_control = 1'b0;
    logic [WCTRL-1:0] data_in_control = '0;
    logic [WCTRL-1:0] data_out_control;
    logic [CORES-1:0] interrupt_start;
    logic [CORES-1:0] interrupt_finish = '0;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [CORES-1:0] m_run, m_done, m_err, m_mask, m_pulse;
    int               m_el [CORES];
    logic [WCTRL-1:0] m_dout;
    logic             m_irq;
    logic             m_active;

    videocard_dispatch #(
        .CORES(CORES),
        .WIDTH_CTRL(WCTRL),
        .TIMEOUT(TMO)
    ) dut (
        .clk               (clk),
        .reset_sink_reset_n(rst_n),
        .address_control   (address_control),
        .read_control      (read_control),
        .write_control     (write_control),
        .data_in_control   (data_in_control),
        .data_out_control  (data_out_control),
        .interrupt_start   (interrupt_start),
        .interrupt_finish  (interrupt_finish),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = '0; m_done = '0; m_err = '0; m_mask = '0; m_pulse = '0;
        for (int i = 0; i < CORES; i++) m_el[i] = 0;
        m_dout = '0; m_irq = 1'b0; m_active = 1'b0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_edge(input logic wr, input logic rd, input logic [1:0] a,
                              input logic [WCTRL-1:0] d, input logic [CORES-1:0] fin);
        logic             irq_n;
        logic [CORES-1:0] was;
        irq_n = |((m_done | m_err) & m_mask);
        was   = m_run;
        if (rd) begin
            case (a)
                2'd0: m_dout = WCTRL'(m_run);
                2'd1: m_dout = WCTRL'(m_done);
                2'd2: m_dout = WCTRL'(m_mask);
                default: m_dout = WCTRL'(m_err);
            endcase
        end
        m_pulse = '0;
        for (int i = 0; i < CORES; i++) begin
            logic set_d, set_e;
            set_d = 1'b0; set_e = 1'b0;
            if (was[i]) begin
                if (fin[i]) begin
                    m_run[i] = 1'b0; set_d = 1'b1;
                end else begin
                    m_el[i]++;
                    if (m_el[i] >= TMO) begin
                        m_run[i] = 1'b0; set_e = 1'b1;
                    end
                end
            end
            if (m_active && wr) begin
                if (a == 2'd0 && d[i] && !was[i]) begin
                    m_run[i] = 1'b1; m_el[i] = 0;
                    m_done[i] = 1'b0; m_err[i] = 1'b0; m_pulse[i] = 1'b1;
                end
                if (a == 2'd1 && d[i]) m_done[i] = 1'b0;
                if (a == 2'd3 && d[i]) m_err[i] = 1'b0;
                if (a == 2'd2) m_mask[i] = d[i];
            end
            if (set_d) m_done[i] = 1'b1;
            if (set_e) m_err[i] = 1'b1;
        end
        m_irq    = irq_n;
        m_active = 1'b1;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [1:0] a,
                        input logic [WCTRL-1:0] d, input logic [CORES-1:0] fin);
        write_control    = wr;
        read_control     = rd;
        address_control  = a;
        data_in_control  = d;
        interrupt_finish = fin;
        @(posedge clk);
        model_edge(wr, rd, a, d, fin);
        #1;
        check("start_pulse", interrupt_start, m_pulse);
        check("irq", irq, m_irq);
        check("rdata", data_out_control, m_dout);
        write_control = 1'b0; read_control = 1'b0; interrupt_finish = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_start", interrupt_start, 4'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_rdata", data_out_control, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", interrupt_start, 4'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_rdata", data_out_control, 8'h00);
        rst_n = 1'b1;

        // first cycle after release: write is ignored
        step(1'b1, 1'b0, 2'd0, 8'h0F, 4'h0);
        check("first_cycle_ignored", interrupt_start, 4'h0);
        step(1'b0, 1'b1, 2'd0, 8'h00, 4'h0);
        check("first_cycle_run", data_out_control, 8'h00);

        // start cores 0 and 2
        step(1'b1, 1'b0, 2'd0, 8'h05, 4'h0);
        check("req032_pulse", interrupt_start, 4'b0101);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        check("req032_pulse_gone", interrupt_start, 4'b0000);
        step(1'b0, 1'b1, 2'd0, 8'h00, 4'h0);
        check("req032_run", data_out_control, 8'h05);
        idle(8);
        step(1'b0, 1'b1, 2'd3, 8'h00, 4'h0);
        check("timeout_err_02", data_out_control, 8'h05);

        // finish on core 0 with mask
        step(1'b1, 1'b0, 2'd2, 8'h01, 4'h0);
        step(1'b1, 1'b0, 2'd0, 8'h01, 4'h0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h1);
        step(1'b0, 1'b1, 2'd1, 8'h00, 4'h0);
        check("req033_done", data_out_control, 8'h01);
        check("req033_irq", irq, 1'b1);
        step(1'b1, 1'b0, 2'd1, 8'h01, 4'h0);
        step(1'b0, 1'b1, 2'd1, 8'h00, 4'h0);
        check("req033_irq_clr", irq, 1'b0);
        check("req033_done_clr", data_out_control, 8'h00);

        // timeout on core 1
        step(1'b1, 1'b0, 2'd0, 8'h02, 4'h0);
        idle(9);
        step(1'b0, 1'b1, 2'd0, 8'h00, 4'h0);
        check("req034_still_run", data_out_control, 8'h02);
        step(1'b0, 1'b1, 2'd3, 8'h00, 4'h0);
        check("req034_err", data_out_control & 8'h02, 8'h02);
        step(1'b0, 1'b1, 2'd0, 8'h00, 4'h0);
        check("req034_run0", data_out_control, 8'h00);

        // finish and timeout coincide, with W1C of DONE in the same cycle
        step(1'b1, 1'b0, 2'd0, 8'h08, 4'h0);
        idle(9);
        step(1'b1, 1'b0, 2'd1, 8'h08, 4'h8);
        step(1'b0, 1'b1, 2'd1, 8'h00, 4'h0);
        check("req035_done", data_out_control & 8'h08, 8'h08);
        step(1'b0, 1'b1, 2'd3, 8'h00, 4'h0);
        check("req035_noerr", data_out_control & 8'h08, 8'h00);

        // restart while running, then reset mid-run
        step(1'b1, 1'b0, 2'd0, 8'h08, 4'h0);
        check("req036_pulse", interrupt_start, 4'h8);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        step(1'b1, 1'b0, 2'd0, 8'h08, 4'h0);
        check("req036_no_repulse", interrupt_start, 4'h0);
        step(1'b0, 1'b1, 2'd0, 8'h00, 4'h0);
        do_reset();
        idle(1);
        for (int r = 0; r < 4; r++) begin
            step(1'b0, 1'b1, 2'(r), 8'h00, 4'h0);
            check("req036_reg_zero", data_out_control, 8'h00);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic             wr, rd;
            logic [1:0]       a;
            logic [WCTRL-1:0] d;
            logic [CORES-1:0] fin;
            if (n == 1500) do_reset();
            wr = ($urandom_range(0, 9) < 4);
            rd = ($urandom_range(0, 1) == 1);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            for (int i = 0; i < CORES; i++) fin[i] = ($urandom_range(0, 7) == 0);
            step(wr, rd, a, d, fin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
